// File: rtl/kiscv_pkg.sv
// Shared KISC-V decode constants, PC-unit state encoding and immediate extractors.
package kiscv_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOLD = 2'd1,
    S_TRAP = 2'd2
  } pcu_state_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Fetch/decode side bundle of the PC unit: instruction and operands in, PC, link and trap out.
interface pc_branch_unit_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            stall;
  logic [XLEN-1:0] pc;
  logic            taken;
  logic            rd_wr;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] rd_data;
  logic            trap;
  logic [XLEN-1:0] trap_pc;

  modport master (
    output instr_valid, instr, rs1_val, rs2_val, stall,
    input  pc, taken, rd_wr, rd_idx, rd_data, trap, trap_pc
  );

  modport slave (
    input  instr_valid, instr, rs1_val, rs2_val, stall,
    output pc, taken, rd_wr, rd_idx, rd_data, trap, trap_pc
  );
endinterface

// File: rtl/branch_cmp.sv
// Conditional-branch comparator: decides take/not-take from funct3 and flags unused encodings.
module branch_cmp
  import kiscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            take,
  output logic            illegal
);

  // Compare selection; 010/011 have no branch meaning and are reported illegal.
  always_comb begin
    take    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  take = (a == b);
      F3_BNE:  take = (a != b);
      F3_BLT:  take = ($signed(a) < $signed(b));
      F3_BGE:  take = ($signed(a) >= $signed(b));
      F3_BLTU: take = (a < b);
      F3_BGEU: take = (a >= b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and control-transfer unit: sequential fetch, JAL/JALR, conditional
// branches, stall hold and a sticky trap on illegal branches or misaligned targets.
module pc_branch_unit
  import kiscv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter bit              BYTE_ADDR    = 1'b1,
  parameter bit              ALIGN_CHECK  = 1'b1
) (
  input  logic            clk,
  input  logic            rts,
  pc_branch_unit_if.slave bus
);

  localparam logic [XLEN-1:0] STEP     = BYTE_ADDR ? XLEN'(32'd4) : XLEN'(32'd1);
  localparam bit              CHECK_EN = BYTE_ADDR && ALIGN_CHECK;

  pcu_state_t             r_state, w_state_nxt;
  logic [XLEN-1:0]        r_pc, w_pc_nxt;
  logic                   r_taken, w_taken_nxt;
  logic                   r_rd_wr, w_rd_wr_nxt;
  logic [4:0]             r_rd_idx, w_rd_idx_nxt;
  logic [XLEN-1:0]        r_rd_data, w_rd_data_nxt;
  logic                   r_trap, w_trap_nxt;
  logic [XLEN-1:0]        r_trap_pc, w_trap_pc_nxt;

  logic [6:0]             w_opcode;
  logic [4:0]             w_rd;
  logic [2:0]             w_funct3;
  logic signed [XLEN-1:0] w_imm_i, w_imm_b, w_imm_j;
  logic [XLEN-1:0]        w_off_b, w_off_j, w_jalr_sum, w_jalr_tgt, w_seq, w_target;
  logic                   w_cmp_take, w_cmp_illegal, w_xfer, w_link, w_illegal, w_misalign;

  assign w_opcode   = bus.instr[6:0];
  assign w_rd       = bus.instr[11:7];
  assign w_funct3   = bus.instr[14:12];
  assign w_imm_i    = XLEN'($signed(imm_i(bus.instr)));
  assign w_imm_b    = XLEN'($signed(imm_b(bus.instr)));
  assign w_imm_j    = XLEN'($signed(imm_j(bus.instr)));
  assign w_seq      = r_pc + STEP;
  assign w_jalr_sum = bus.rs1_val + w_imm_i;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3  (w_funct3),
    .a       (bus.rs1_val),
    .b       (bus.rs2_val),
    .take    (w_cmp_take),
    .illegal (w_cmp_illegal)
  );

  // Word-addressed PCs count instructions, so byte offsets and JALR sums lose two bits.
  always_comb begin
    if (BYTE_ADDR) begin
      w_off_b    = w_imm_b;
      w_off_j    = w_imm_j;
      w_jalr_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};
    end else begin
      w_off_b    = w_imm_b >>> 2;
      w_off_j    = w_imm_j >>> 2;
      w_jalr_tgt = {2'b00, w_jalr_sum[XLEN-1:2]};
    end
  end

  // Instruction decode: transfer target, link request and illegal-branch detection.
  always_comb begin
    w_xfer    = 1'b0;
    w_link    = 1'b0;
    w_illegal = 1'b0;
    w_target  = w_seq;
    case (w_opcode)
      OP_JAL: begin
        w_xfer   = 1'b1;
        w_link   = 1'b1;
        w_target = r_pc + w_off_j;
      end
      OP_JALR: begin
        w_xfer   = 1'b1;
        w_link   = 1'b1;
        w_target = w_jalr_tgt;
      end
      OP_BRANCH: begin
        w_illegal = w_cmp_illegal;
        w_xfer    = w_cmp_take;
        if (w_cmp_take) begin
          w_target = r_pc + w_off_b;
        end else begin
          w_target = w_seq;
        end
      end
      default: w_xfer = 1'b0;
    endcase
  end

  assign w_misalign = CHECK_EN && w_xfer && (w_target[1:0] != 2'b00);

  // Next-state logic; HOLD accepts on its first stall-free cycle just like RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_taken_nxt   = 1'b0;
    w_rd_wr_nxt   = 1'b0;
    w_rd_idx_nxt  = r_rd_idx;
    w_rd_data_nxt = r_rd_data;
    w_trap_nxt    = r_trap;
    w_trap_pc_nxt = r_trap_pc;
    case (r_state)
      S_RUN, S_HOLD: begin
        if (bus.stall) begin
          w_state_nxt = S_HOLD;
        end else if (!bus.instr_valid) begin
          w_state_nxt = S_RUN;
        end else if (w_illegal || w_misalign) begin
          w_state_nxt   = S_TRAP;
          w_trap_nxt    = 1'b1;
          w_trap_pc_nxt = r_pc;
        end else begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = w_target;
          w_taken_nxt = w_xfer;
          if (w_link && (w_rd != 5'd0)) begin
            w_rd_wr_nxt   = 1'b1;
            w_rd_idx_nxt  = w_rd;
            w_rd_data_nxt = w_seq;
          end else begin
            w_rd_wr_nxt = 1'b0;
          end
        end
      end
      S_TRAP:  w_state_nxt = S_TRAP;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State and output registers; reset is asynchronous so outputs clear without a clock.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_VECTOR;
      r_taken   <= 1'b0;
      r_rd_wr   <= 1'b0;
      r_rd_idx  <= 5'd0;
      r_rd_data <= {XLEN{1'b0}};
      r_trap    <= 1'b0;
      r_trap_pc <= {XLEN{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_taken   <= w_taken_nxt;
      r_rd_wr   <= w_rd_wr_nxt;
      r_rd_idx  <= w_rd_idx_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_trap    <= w_trap_nxt;
      r_trap_pc <= w_trap_pc_nxt;
    end
  end

  assign bus.pc      = r_pc;
  assign bus.taken   = r_taken;
  assign bus.rd_wr   = r_rd_wr;
  assign bus.rd_idx  = r_rd_idx;
  assign bus.rd_data = r_rd_data;
  assign bus.trap    = r_trap;
  assign bus.trap_pc = r_trap_pc;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a byte-mode and a word-mode instance share stimulus,
// and the instance selected by sel is checked against a behavioural reference model.
module tb_pc_branch_unit;
  import kiscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        rd_wr;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic        trap;
    logic [31:0] trap_pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rts = 1'b1;
  logic        sel = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_instr = 32'd0;
  logic [31:0] s_rs1 = 32'd0;
  logic [31:0] s_rs2 = 32'd0;
  logic        s_stall = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb_q[$];

  logic [31:0] m_pc;
  logic [31:0] m_trap_pc;
  logic        m_trap;
  logic        m_byte;
  int          m_state;

  always #5 clk = ~clk;

  pc_branch_unit_if #(.XLEN(32)) bif ();
  pc_branch_unit_if #(.XLEN(32)) wif ();

  assign bif.instr_valid = s_valid;
  assign bif.instr       = s_instr;
  assign bif.rs1_val     = s_rs1;
  assign bif.rs2_val     = s_rs2;
  assign bif.stall       = s_stall;
  assign wif.instr_valid = s_valid;
  assign wif.instr       = s_instr;
  assign wif.rs1_val     = s_rs1;
  assign wif.rs2_val     = s_rs2;
  assign wif.stall       = s_stall;

  pc_branch_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .BYTE_ADDR(1'b1), .ALIGN_CHECK(1'b1)) u_byte (
    .clk (clk), .rts (rts), .bus (bif.slave)
  );

  pc_branch_unit #(.XLEN(32), .RESET_VECTOR(32'h5), .BYTE_ADDR(1'b0), .ALIGN_CHECK(1'b1)) u_word (
    .clk (clk), .rts (rts), .bus (wif.slave)
  );

  logic [31:0] o_pc, o_rd_data, o_trap_pc;
  logic        o_taken, o_rd_wr, o_trap;
  logic [4:0]  o_rd_idx;
  assign o_pc      = sel ? wif.pc      : bif.pc;
  assign o_taken   = sel ? wif.taken   : bif.taken;
  assign o_rd_wr   = sel ? wif.rd_wr   : bif.rd_wr;
  assign o_rd_idx  = sel ? wif.rd_idx  : bif.rd_idx;
  assign o_rd_data = sel ? wif.rd_data : bif.rd_data;
  assign o_trap    = sel ? wif.trap    : bif.trap;
  assign o_trap_pc = sel ? wif.trap_pc : bif.trap_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input int off);
    return {off[20], off[10:1], off[11], off[19:12], rd, OP_JAL};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int off);
    return {off[12], off[10:5], 5'd2, 5'd1, f3, off[4:1], off[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input int imm);
    return {imm[11:0], 5'd1, 3'b000, rd, OP_JALR};
  endfunction

  // Reference model step, scoreboard push, one clock, then pop and compare.
  task automatic cycle(input string tag, input logic valid, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b, input logic stl,
                       input logic xfer, input logic [31:0] tgt, input logic link,
                       input logic [4:0] rd, input logic ill);
    exp_t e;
    logic [31:0] step;
    step      = m_byte ? 32'd4 : 32'd1;
    e.taken   = 1'b0;
    e.rd_wr   = 1'b0;
    e.rd_idx  = 5'd0;
    e.rd_data = 32'd0;
    if (m_state != 2) begin
      if (stl) begin
        m_state = 1;
      end else if (valid) begin
        m_state = 0;
        if (ill || (xfer && m_byte && (tgt[1:0] != 2'b00))) begin
          m_state   = 2;
          m_trap    = 1'b1;
          m_trap_pc = m_pc;
        end else begin
          e.taken = xfer;
          if (link && (rd != 5'd0)) begin
            e.rd_wr   = 1'b1;
            e.rd_idx  = rd;
            e.rd_data = m_pc + step;
          end
          m_pc = xfer ? tgt : (m_pc + step);
        end
      end else begin
        m_state = 0;
      end
    end
    e.pc      = m_pc;
    e.trap    = m_trap;
    e.trap_pc = m_trap_pc;
    sb_q.push_back(e);
    s_valid = valid;
    s_instr = ins;
    s_rs1   = a;
    s_rs2   = b;
    s_stall = stl;
    @(posedge clk);
    #1;
    chk({tag, "/sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "/pc"}, o_pc, e.pc);
      chk({tag, "/taken"}, 32'(o_taken), 32'(e.taken));
      chk({tag, "/rd_wr"}, 32'(o_rd_wr), 32'(e.rd_wr));
      chk({tag, "/trap"}, 32'(o_trap), 32'(e.trap));
      chk({tag, "/trap_pc"}, o_trap_pc, e.trap_pc);
      if (e.rd_wr) begin
        chk({tag, "/rd_idx"}, 32'(o_rd_idx), 32'(e.rd_idx));
        chk({tag, "/rd_data"}, o_rd_data, e.rd_data);
      end
    end
    s_valid = 1'b0;
    s_stall = 1'b0;
  endtask

  task automatic do_nop(input string tag);
    cycle(tag, 1'b1, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_idle(input string tag);
    cycle(tag, 1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_jal(input string tag, input logic [4:0] rd, input int off);
    logic [31:0] tgt;
    tgt = m_pc + (m_byte ? 32'(off) : 32'(off >>> 2));
    cycle(tag, 1'b1, enc_j(rd, off), 32'd0, 32'd0, 1'b0, 1'b1, tgt, 1'b1, rd, 1'b0);
  endtask

  task automatic do_jalr(input string tag, input logic [4:0] rd, input int imm, input logic [31:0] rs1);
    logic [31:0] s;
    s = (rs1 + 32'(imm)) & 32'hFFFF_FFFE;
    cycle(tag, 1'b1, enc_jalr(rd, imm), rs1, 32'd0, 1'b0, 1'b1, m_byte ? s : (s >> 2), 1'b1, rd, 1'b0);
  endtask

  task automatic do_br(input string tag, input logic [2:0] f3, input int off,
                       input logic [31:0] a, input logic [31:0] b, input logic stl);
    logic take;
    logic ill;
    take = 1'b0;
    ill  = 1'b0;
    case (f3)
      3'd0: take = (a == b);
      3'd1: take = (a != b);
      3'd4: take = ($signed(a) < $signed(b));
      3'd5: take = !($signed(a) < $signed(b));
      3'd6: take = (a < b);
      3'd7: take = !(a < b);
      default: ill = 1'b1;
    endcase
    cycle(tag, 1'b1, enc_b(f3, off), a, b, stl, take,
          m_pc + (m_byte ? 32'(off) : 32'(off >>> 2)), 1'b0, 5'd0, ill);
  endtask

  // Raise reset mid-cycle, check outputs before any clock edge, release after the next edge.
  task automatic do_reset(input string tag, input logic [31:0] rv);
    #2;
    rts = 1'b1;
    #1;
    chk({tag, "/pc"}, o_pc, rv);
    chk({tag, "/taken"}, 32'(o_taken), 32'd0);
    chk({tag, "/rd_wr"}, 32'(o_rd_wr), 32'd0);
    chk({tag, "/rd_idx"}, 32'(o_rd_idx), 32'd0);
    chk({tag, "/rd_data"}, o_rd_data, 32'd0);
    chk({tag, "/trap"}, 32'(o_trap), 32'd0);
    chk({tag, "/trap_pc"}, o_trap_pc, 32'd0);
    m_pc      = rv;
    m_state   = 0;
    m_trap    = 1'b0;
    m_trap_pc = 32'd0;
    @(posedge clk);
    #1;
    rts = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    sel    = 1'b0;
    m_byte = 1'b1;
    @(posedge clk);
    #1;
    do_reset("reset", 32'h100);
    for (int i = 0; i < 10; i++) do_nop("nop");
    chk("nop_end_pc", o_pc, 32'h128);
    do_idle("idle");

    do_jalr("go40", 5'd0, 0, 32'h40);
    do_br("blt", 3'b100, 16, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("blt_pc", o_pc, 32'h50);
    chk("blt_taken", 32'(o_taken), 32'd1);
    do_jalr("go40b", 5'd0, 0, 32'h40);
    do_br("bltu", 3'b110, 16, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("bltu_pc", o_pc, 32'h44);

    do_jalr("go20", 5'd0, 0, 32'h20);
    do_jal("jal_rd1", 5'd1, -8);
    chk("jal_rd1_pc", o_pc, 32'h18);
    chk("jal_rd1_data", o_rd_data, 32'h24);
    do_jalr("go20b", 5'd0, 0, 32'h20);
    do_jal("jal_rd0", 5'd0, -8);
    chk("jal_rd0_wr", 32'(o_rd_wr), 32'd0);

    for (int i = 0; i < 3; i++) do_br("beq_stall", 3'b000, 8, 32'd5, 32'd5, 1'b1);
    do_br("beq_go", 3'b000, 8, 32'd5, 32'd5, 1'b0);
    chk("beq_go_pc", o_pc, 32'h20);
    do_br("hold_enter", 3'b000, 8, 32'd5, 32'd5, 1'b1);
    do_reset("rst_in_hold", 32'h100);

    do_jalr("jalr204", 5'd0, 2, 32'h203);
    chk("jalr204_pc", o_pc, 32'h204);
    do_jalr("jalr202", 5'd1, 2, 32'h200);
    chk("jalr202_trap_pc", o_trap_pc, 32'h204);
    for (int i = 0; i < 3; i++) do_nop("trap_nop");
    do_jal("trap_jal", 5'd2, 16);
    chk("trap_frozen_pc", o_pc, 32'h204);
    do_reset("rst_in_trap", 32'h100);
    do_br("illegal_f3", 3'b010, 8, 32'd0, 32'd0, 1'b0);
    do_br("misalign_br", 3'b000, 6, 32'd0, 32'd0, 1'b0);

    sel    = 1'b1;
    m_byte = 1'b0;
    do_reset("rst_word", 32'h5);
    do_br("bne_word", 3'b001, 12, 32'd1, 32'd2, 1'b0);
    chk("bne_word_pc", o_pc, 32'h8);
    do_jal("jal_to_top", 5'd0, -36);
    chk("top_pc", o_pc, 32'hFFFF_FFFF);
    do_nop("wrap");
    chk("wrap_pc", o_pc, 32'h0);
    do_jal("jal_word_link", 5'd3, 8);
    chk("word_link_data", o_rd_data, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
